wall_engine: RTL

Parametrised multi-wall obstacle engine for the 160x120, 3-bit-colour VGA game. On each frame tick it scrolls `N_WALLS` gapped walls left, erases and redraws them pixel-by-pixel through the VGA adapter plot port, re-spawns walls that leave the screen with a new gap position, and keeps the score and a bird-collision flag. It sits between the game control FSM, which supplies `frame_tick`, `enable` and `bird_y`, and the VGA adapter, which consumes `x_out`, `y_out`, `colour_out` and `plot`.

---
 rtl/wall_pkg.sv | 29 ++
 rtl/wall_engine_if.sv | 30 +++
 rtl/lfsr8.sv | 21 ++
 rtl/wall_engine.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wall_pkg.sv
// ---------------------------------------------------------------------------
// wall_pkg: shared constants, FSM encoding and wall-range check. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wall_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [2:0] WALL_COLOUR       = 3'b100;
  localparam logic [2:0] BACKGROUND_COLOUR = 3'b111;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ERASE  = 3'd1;
  localparam state_t ST_UPDATE = 3'd2;
  localparam state_t ST_DRAW   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // True when the right-most wall at reset still fits fully on screen.
  function automatic bit walls_fit(input int start, input int spacing, input int n_walls,
                                   input int width, input int screen_w);
    return (start + (n_walls - 1) * spacing) <= (screen_w - width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wall_engine_if.sv
// ---------------------------------------------------------------------------
// wall_engine_if: game-control inputs and VGA plot/status outputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface wall_engine_if;
  logic       frame_tick;
  logic       enable;
  logic [6:0] bird_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic [7:0] score_out;
  logic       collide;
  logic       busy;
  logic       frame_done;

  modport master (
    input  frame_tick, enable, bird_y,
    output x_out, y_out, colour_out, plot, score_out, collide, busy, frame_done
  );

  modport slave (
    output frame_tick, enable, bird_y,
    input  x_out, y_out, colour_out, plot, score_out, collide, busy, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8: 8-bit maximal LFSR (taps 8,6,5,4), used under WALL_RANDOM_GAP_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= SEED;
    else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

`default_nettype wire

// File: rtl/wall_engine.sv
// ---------------------------------------------------------------------------
// wall_engine: scrolls, erases and redraws gapped walls; keeps score/collide.
// WALL_RANDOM_GAP_EN selects LFSR gap positions on wrap. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wall_engine
  import wall_pkg::*;
#(
  parameter int N_WALLS      = 2,
  parameter int WALL_WIDTH   = 10,
  parameter int WALL_SPEED   = 4,
  parameter int GAP_HEIGHT   = 40,
  parameter int WALL_X_START = 70,
  parameter int WALL_SPACING = 80,
  parameter int BIRD_X       = 40,
  parameter int BIRD_H       = 8,
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF
) (
  input  logic          clk,
  input  logic          reset,
  wall_engine_if.master bus
);

  localparam int IW      = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;
  localparam int GAP_MAX = SCREEN_H - GAP_HEIGHT;

  if (!walls_fit(WALL_X_START, WALL_SPACING, N_WALLS, WALL_WIDTH, SCREEN_W)) begin : g_range_check
    $error("wall_engine: initial wall positions exceed the screen width");
  end

  state_t        state;
  logic [IW-1:0] idx, next_idx;
  logic [7:0]    wall_x [N_WALLS];
  logic [6:0]    gap_y  [N_WALLS];
  logic [7:0]    xo, nxo;
  logic [6:0]    yc, nyc;
  logic          last_px, wrap, hit;
  logic [7:0]    new_x;
  logic [6:0]    new_gap, next_gap;

`ifdef WALL_RANDOM_GAP_EN
  logic [7:0] lfsr_q;
  lfsr8 #(.SEED(8'hA5)) u_lfsr (.clk(clk), .reset(reset), .q(lfsr_q));
  // Fold 0..127 into 0..GAP_MAX so the whole gap stays on screen.
  always_comb begin
    next_gap = lfsr_q[6:0];
    if (lfsr_q[6:0] > 7'(GAP_MAX)) next_gap = lfsr_q[6:0] - 7'(GAP_MAX + 1);
  end
`else
  assign next_gap = 7'd40;
`endif

  function automatic logic [2:0] draw_colour(input logic [6:0] y, input logic [6:0] gap);
    if (y >= gap && {1'b0, y} < ({1'b0, gap} + 8'(GAP_HEIGHT))) return BACKGROUND_COLOUR;
    return WALL_COLOUR;
  endfunction

  // Column-major scan: y is the inner counter.
  always_comb begin
    if (yc == 7'(SCREEN_H - 1)) begin
      nyc = '0;
      nxo = xo + 8'd1;
    end else begin
      nyc = yc + 7'd1;
      nxo = xo;
    end
    last_px  = (xo == 8'(WALL_WIDTH - 1)) && (yc == 7'(SCREEN_H - 1));
    next_idx = idx + IW'(1);
    wrap     = wall_x[idx] < 8'(WALL_SPEED);
    new_x    = wrap ? 8'(SCREEN_W - WALL_WIDTH) : wall_x[idx] - 8'(WALL_SPEED);
    new_gap  = wrap ? next_gap : gap_y[idx];
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_WALLS; i++) begin
      if ({1'b0, wall_x[i]} <= 9'(BIRD_X) &&
          9'(BIRD_X) < ({1'b0, wall_x[i]} + 9'(WALL_WIDTH)) &&
          (bus.bird_y < gap_y[i] ||
           ({1'b0, bus.bird_y} + 8'(BIRD_H)) > ({1'b0, gap_y[i]} + 8'(GAP_HEIGHT))))
        hit = 1'b1;
    end
  end

  // Outputs are registered one pixel ahead: each edge loads the pixel shown next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      xo             <= '0;
      yc             <= '0;
      bus.x_out      <= '0;
      bus.y_out      <= '0;
      bus.colour_out <= BACKGROUND_COLOUR;
      bus.plot       <= 1'b0;
      bus.score_out  <= '0;
      bus.collide    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      for (int i = 0; i < N_WALLS; i++) begin
        wall_x[i] <= 8'(WALL_X_START + i * WALL_SPACING);
        gap_y[i]  <= 7'd40;
      end
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.frame_tick && bus.enable) begin
            state          <= ST_ERASE;
            idx            <= '0;
            xo             <= '0;
            yc             <= '0;
            bus.busy       <= 1'b1;
            bus.plot       <= 1'b1;
            bus.x_out      <= wall_x[0];
            bus.y_out      <= '0;
            bus.colour_out <= BACKGROUND_COLOUR;
          end
        end
        ST_ERASE: begin
          if (last_px) begin
            state    <= ST_UPDATE;
            bus.plot <= 1'b0;
          end else begin
            xo        <= nxo;
            yc        <= nyc;
            bus.x_out <= wall_x[idx] + nxo;
            bus.y_out <= nyc;
          end
        end
        ST_UPDATE: begin
          wall_x[idx] <= new_x;
          gap_y[idx]  <= new_gap;
          if (!wrap && wall_x[idx] >= 8'(BIRD_X) && new_x < 8'(BIRD_X) &&
              bus.score_out != 8'hFF)
            bus.score_out <= bus.score_out + 8'd1;
          state          <= ST_DRAW;
          xo             <= '0;
          yc             <= '0;
          bus.plot       <= 1'b1;
          bus.x_out      <= new_x;
          bus.y_out      <= '0;
          bus.colour_out <= draw_colour(7'd0, new_gap);
        end
        ST_DRAW: begin
          if (!last_px) begin
            xo             <= nxo;
            yc             <= nyc;
            bus.x_out      <= wall_x[idx] + nxo;
            bus.y_out      <= nyc;
            bus.colour_out <= draw_colour(nyc, gap_y[idx]);
          end else if (idx == IW'(N_WALLS - 1)) begin
            state          <= ST_DONE;
            bus.plot       <= 1'b0;
            bus.frame_done <= 1'b1;
            bus.collide    <= hit;
          end else begin
            state          <= ST_ERASE;
            idx            <= next_idx;
            xo             <= '0;
            yc             <= '0;
            bus.x_out      <= wall_x[next_idx];
            bus.y_out      <= '0;
            bus.colour_out <= BACKGROUND_COLOUR;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
